// File: rtl/addsub_pkg.sv
// Shared definitions for the arbitrated add/subtract block.
package addsub_pkg;

  // Requester index width (two requesters).
  localparam int ID_W = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/adder_subtractor_nbits.sv
// n-bit adder/subtractor: add_n = 0 gives x + y, add_n = 1 gives x + ~y + 1.
// c_out is the carry out of bit n-1; overflow compares the carries into
// and out of the MSB.
module adder_subtractor_nbits #(
  parameter int n = 4
) (
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  input  logic         add_n,
  output logic [n-1:0] s,
  output logic         c_out,
  output logic         overflow
);

  logic [n-1:0] y_eff;
  logic [n:0]   full;
  logic         c_into_msb;

  // Invert y for subtraction and feed add_n in as the carry-in.
  always_comb begin
    y_eff      = add_n ? ~y : y;
    full       = {1'b0, x} + {1'b0, y_eff} + {{n{1'b0}}, add_n};
    s          = full[n-1:0];
    c_out      = full[n];
    c_into_msb = x[n-1] ^ y_eff[n-1] ^ full[n-1];
    overflow   = c_into_msb ^ c_out;
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Two requesters share one adder/subtractor. A request is accepted in IDLE,
// computed in EXEC, and the result is held in RESP until consumed.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. Requesters may drop valid at any time before that edge; the
// block only looks at operands on the accepting edge. rsp_* are registered
// and stay stable while rsp_valid is 1 and rsp_ready is 0.
module addsub_arbiter
  import addsub_pkg::*;
#(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [n-1:0] req0_x,
  input  logic [n-1:0] req0_y,
  input  logic         req0_add_n,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [n-1:0] req1_x,
  input  logic [n-1:0] req1_y,
  input  logic         req1_add_n,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [n-1:0] rsp_s,
  output logic         rsp_c_out,
  output logic         rsp_overflow,
  output logic         rsp_id,
  output logic [1:0]   dbg_state
);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   last_served_q;
  logic [n-1:0]      x_q, y_q;
  logic              add_n_q;
  logic [ID_W-1:0]   id_q;

  logic              grant_valid;
  logic [ID_W-1:0]   grant_id;
  logic              accept;

  logic [n-1:0]      alu_s;
  logic              alu_c_out;
  logic              alu_overflow;

  adder_subtractor_nbits #(.n(n)) u_alu (
    .x        (x_q),
    .y        (y_q),
    .add_n    (add_n_q),
    .s        (alu_s),
    .c_out    (alu_c_out),
    .overflow (alu_overflow)
  );

  // Grant selection: sole valid requester, otherwise the one not served last.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    if (req0_valid && req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = ~last_served_q;
    end else if (req0_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b0;
    end else if (req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b1;
    end
  end

  assign req0_ready = !rst && (state_q == IDLE) && grant_valid && (grant_id == 1'b0);
  assign req1_ready = !rst && (state_q == IDLE) && grant_valid && (grant_id == 1'b1);
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign dbg_state  = state_q;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, operand latch, result and last-served registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_served_q <= 1'b1;
      x_q           <= '0;
      y_q           <= '0;
      add_n_q       <= 1'b0;
      id_q          <= '0;
      rsp_valid     <= 1'b0;
      rsp_s         <= '0;
      rsp_c_out     <= 1'b0;
      rsp_overflow  <= 1'b0;
      rsp_id        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        x_q     <= grant_id ? req1_x     : req0_x;
        y_q     <= grant_id ? req1_y     : req0_y;
        add_n_q <= grant_id ? req1_add_n : req0_add_n;
        id_q    <= grant_id;
      end
      if (state_q == EXEC) begin
        rsp_s        <= alu_s;
        rsp_c_out    <= alu_c_out;
        rsp_overflow <= alu_overflow;
        rsp_id       <= id_q;
        rsp_valid    <= 1'b1;
      end
      if ((state_q == RESP) && rsp_ready) begin
        rsp_valid     <= 1'b0;
        last_served_q <= rsp_id;
      end
    end
  end

endmodule

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 Parameter: n, default 4, operand/result width in bits.
REQ-002 clk  input  1  rising-edge clock, sole clock of the block.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0_valid / req1_valid  input  1 each  requester 0/1 has an operation pending.
REQ-005 req0_ready / req1_ready  output  1 each  block accepts requester 0/1 this cycle.
REQ-006 req0_x, req0_y, req1_x, req1_y  input  n each  operands.
REQ-007 req0_add_n / req1_add_n  input  1 each  0 = x+y, 1 = x-y.
REQ-008 rsp_valid  output  1  result held on rsp_* outputs.
REQ-009 rsp_ready  input  1  consumer accepts the result.
REQ-010 rsp_s  output  n  sum/difference, modulo 2^n.
REQ-011 rsp_c_out / rsp_overflow / rsp_id  output  1 each  carry-out, signed two's-complement overflow, requester index (0/1).

Function
REQ-012 The block SHALL share one adder/subtractor datapath between two requesters using FSM states IDLE, EXEC, RESP.
REQ-013 IDLE: grant = sole valid requester; if both are valid, grant the requester not served last; req*_ready SHALL be 1 only for the granted requester, and only in IDLE.
REQ-014 On handshake (valid & ready) the block SHALL latch x, y, add_n, and id, and go to EXEC next cycle.
REQ-015 EXEC: one cycle; the block SHALL register s, c_out, and overflow from the latched operands, and go to RESP with rsp_valid = 1.
REQ-016 Latency: rsp_valid SHALL rise exactly 2 clk edges after the accepting edge; throughput is at most one operation per 3 cycles.
REQ-017 Subtraction SHALL be computed as x + ~y + 1; c_out is the carry out of bit n-1 (1 = no borrow); overflow = carry into MSB XOR carry out of MSB.
REQ-018 RESP: all rsp_* outputs SHALL stay stable while rsp_valid & !rsp_ready; on rsp_ready the block SHALL go to IDLE, drop rsp_valid, and record rsp_id as last served.
REQ-019 With a single requester continuously valid, it SHALL be granted on every IDLE visit (no starvation by the idle requester).
REQ-020 A requester that drops valid before a handshake SHALL NOT be accepted; no operands are latched without a handshake.
REQ-021 While not in IDLE, req0_ready = req1_ready = 0 regardless of valids.
REQ-022 A rsp_ready asserted outside RESP SHALL have no effect.

Reset
REQ-023 While rst = 1 at a clk edge: state = IDLE, rsp_valid = 0, rsp_s = 0, rsp_c_out = 0, rsp_overflow = 0, rsp_id = 0, last-served = 1 (requester 0 wins the first tie).
REQ-024 Reset during EXEC or RESP SHALL discard the in-flight operation without producing a response.
REQ-025 req*_ready SHALL be 0 during any cycle in which rst = 1.

Structure
REQ-026 State encodings (IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2) and the requester-ID width SHALL live in shared package addsub_pkg.
REQ-027 The arithmetic SHALL be one instance of the existing adder_subtractor_nbits (parameter n); no other sub-module.
REQ-028 All state and output registers SHALL use clk only; there SHALL be no combinational path from rsp_ready to rsp_* data outputs.

Verification (n = 4)
REQ-029 req0: x=4, y=5, add_n=0, rsp_ready=1 -> after 2 edges rsp_s=9, c_out=0, overflow=1, id=0.
REQ-030 req1: x=2, y=6, add_n=1 -> rsp_s=12, c_out=0, overflow=0, id=1; then x=15, y=1, add_n=0 -> rsp_s=0, c_out=1, overflow=0.
REQ-031 Both valid continuously after reset, rsp_ready=1 -> grants alternate 0,1,0,1, and each rsp_id matches the requester granted.
REQ-032 rsp_ready held 0 for 5 cycles in RESP (x=8, y=9, sub) -> rsp_s=15, c_out=0, overflow=0 stable; both ready=0 throughout.
REQ-033 rst asserted in EXEC -> next cycle state IDLE, rsp_valid never asserted, and the next tie is granted to requester 0.
